// File: rtl/spec_pkg.sv
// Shared types and helpers for the FMA special-case handler pipeline:
// operand class struct, flag bit positions and canonical encodings.
package spec_pkg;

  localparam int DEF_EXP_W = 8;
  localparam int DEF_MAN_W = 23;
  localparam int MAX_W     = 128;

  // Bit positions inside the 4-bit flags word {nan_in, invalid, overflow, underflow}
  localparam int FLAG_UNF = 0;
  localparam int FLAG_OVF = 1;
  localparam int FLAG_INV = 2;
  localparam int FLAG_NAN = 3;

  typedef struct packed {
    logic zero;
    logic inf;
    logic nan;
  } fclass_t;

  function automatic int bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // Built at MAX_W and truncated by callers, so any EXP_W/MAN_W combination works
  function automatic logic [MAX_W-1:0] make_inf(input logic sign, input int exp_w, input int man_w);
    logic [MAX_W-1:0] r;
    r = ((MAX_W'(1) << exp_w) - MAX_W'(1)) << man_w;
    r = r | (MAX_W'(sign) << (exp_w + man_w));
    return r;
  endfunction

  function automatic logic [MAX_W-1:0] make_qnan(input int exp_w, input int man_w);
    return make_inf(1'b0, exp_w, man_w) | (MAX_W'(1) << (man_w - 1));
  endfunction

endpackage

// File: rtl/spec_lane_resolve.sv
// Single-lane special-case logic: a classify half feeding the S1 register and
// a resolve half working on the registered S1 view of the same lane.
module spec_lane_resolve
  import spec_pkg::*;
#(
  parameter int EXP_W = DEF_EXP_W,
  parameter int MAN_W = DEF_MAN_W
) (
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  input  logic [EXP_W+MAN_W:0]   c,
  output fclass_t                cls_a,
  output fclass_t                cls_b,
  output fclass_t                cls_c,
  output logic signed [EXP_W+1:0] exp_ab,
  output logic                   sign_ab,
  input  logic [EXP_W+MAN_W:0]   s1_a,
  input  logic [EXP_W+MAN_W:0]   s1_b,
  input  logic [EXP_W+MAN_W:0]   s1_c,
  input  fclass_t                s1_cls_a,
  input  fclass_t                s1_cls_b,
  input  fclass_t                s1_cls_c,
  input  logic signed [EXP_W+1:0] s1_exp_ab,
  input  logic                   s1_sign_ab,
  input  logic                   s1_inv,
  input  logic                   s1_nj,
  output logic                   spec,
  output logic [EXP_W+MAN_W:0]   res,
  output logic [3:0]             flags
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int EW = EXP_W + 2;
  localparam logic [W-1:0]         INF_P    = W'(make_inf(1'b0, EXP_W, MAN_W));
  localparam logic [W-1:0]         QNAN     = W'(make_qnan(EXP_W, MAN_W));
  localparam logic [W-1:0]         QBIT     = W'(1) << (MAN_W - 1);
  localparam logic signed [EW-1:0] BIAS_S   = EW'(bias(EXP_W));
  localparam logic signed [EW-1:0] TWO_BIAS = EW'(2 * bias(EXP_W));
  localparam logic signed [EW-1:0] MIN_EXP  = EW'(1 - bias(EXP_W));

  function automatic fclass_t classify(input logic [W-1:0] x);
    fclass_t r;
    r.zero = (x[W-2:MAN_W] == '0) && (x[MAN_W-1:0] == '0);
    r.inf  = (&x[W-2:MAN_W]) && (x[MAN_W-1:0] == '0);
    r.nan  = (&x[W-2:MAN_W]) && (x[MAN_W-1:0] != '0);
    return r;
  endfunction

  function automatic logic fin_nz(input fclass_t k);
    return ~(k.zero | k.inf | k.nan);
  endfunction

  assign cls_a   = classify(a);
  assign cls_b   = classify(b);
  assign cls_c   = classify(c);
  assign sign_ab = a[W-1] ^ b[W-1];
  // Widened by two bits so the full product exponent range stays exact
  assign exp_ab  = $signed({2'b00, a[W-2:MAN_W]}) + $signed({2'b00, b[W-2:MAN_W]}) - TWO_BIAS;

  logic prod_inf, prod_zero, both_fin, c_finite;
  logic invalid, overflow, underflow;

  assign prod_inf  = s1_cls_a.inf | s1_cls_b.inf;
  assign prod_zero = s1_cls_a.zero | s1_cls_b.zero;
  assign both_fin  = fin_nz(s1_cls_a) & fin_nz(s1_cls_b);
  assign c_finite  = s1_cls_c.zero | fin_nz(s1_cls_c);
  assign invalid   = (s1_cls_a.inf & s1_cls_b.zero) | (s1_cls_a.zero & s1_cls_b.inf) |
                     (s1_inv & s1_cls_c.inf & prod_inf & (s1_sign_ab != s1_c[W-1]));
  assign overflow  = both_fin & (s1_exp_ab > BIAS_S);
  assign underflow = both_fin & (s1_exp_ab < MIN_EXP);

  // Priority chain: the first matching condition decides the lane result
  always_comb begin
    spec  = 1'b0;
    res   = '0;
    flags = '0;
    if (s1_cls_a.nan | s1_cls_b.nan | s1_cls_c.nan) begin
      spec            = 1'b1;
      flags[FLAG_NAN] = 1'b1;
      if (s1_cls_a.nan)      res = s1_a | QBIT;
      else if (s1_cls_b.nan) res = s1_b | QBIT;
      else                   res = s1_c | QBIT;
    end else if (invalid) begin
      spec            = 1'b1;
      flags[FLAG_INV] = 1'b1;
      res             = QNAN;
    end else if (overflow) begin
      spec            = 1'b1;
      flags[FLAG_OVF] = 1'b1;
      res             = {s1_sign_ab, INF_P[W-2:0]};
    end else if (underflow & s1_nj) begin
      spec            = 1'b1;
      flags[FLAG_UNF] = 1'b1;
      res             = s1_c;
    end else if (prod_zero) begin
      spec = 1'b1;
      res  = s1_inv ? s1_c : {s1_sign_ab, {(W-1){1'b0}}};
    end else if (prod_inf) begin
      spec = 1'b1;
      res  = (c_finite | ~s1_inv) ? {s1_sign_ab, INF_P[W-2:0]} : s1_c;
    end else if (s1_cls_c.inf) begin
      spec = 1'b1;
      res  = s1_c;
    end
  end

endmodule

// File: rtl/spec_handler_pipe.sv
// Two-stage elastic pipeline around NLANES spec_lane_resolve instances.
// Optional SPEC_STICKY_FLAGS_EN adds flags_clr / sticky_flags accumulation.
module spec_handler_pipe
  import spec_pkg::*;
#(
  parameter int NLANES = 4,
  parameter int EXP_W  = DEF_EXP_W,
  parameter int MAN_W  = DEF_MAN_W,
  parameter int TAG_W  = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              nj_mode,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [NLANES-1:0]                 in_inv_mask,
  input  logic [NLANES*(1+EXP_W+MAN_W)-1:0] in_a,
  input  logic [NLANES*(1+EXP_W+MAN_W)-1:0] in_b,
  input  logic [NLANES*(1+EXP_W+MAN_W)-1:0] in_c,
  input  logic [TAG_W-1:0]                  in_tag,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [NLANES-1:0]                 out_spec_mask,
  output logic [NLANES*(1+EXP_W+MAN_W)-1:0] out_res,
  output logic [TAG_W-1:0]                  out_tag,
`ifdef SPEC_STICKY_FLAGS_EN
  input  logic                              flags_clr,
  output logic [3:0]                        sticky_flags,
`endif
  output logic [3:0]                        out_flags
);

  localparam int W = 1 + EXP_W + MAN_W;

  logic alive, accept, s1_adv, s2_adv;
  logic s1_valid, s1_nj;
  logic [TAG_W-1:0]    s1_tag;
  logic [NLANES-1:0]   s1_inv, sign_ab, s1_sign_ab, lane_spec;
  logic [NLANES*W-1:0] s1_a, s1_b, s1_c, lane_res;
  fclass_t cls_a [NLANES];
  fclass_t cls_b [NLANES];
  fclass_t cls_c [NLANES];
  fclass_t s1_cls_a [NLANES];
  fclass_t s1_cls_b [NLANES];
  fclass_t s1_cls_c [NLANES];
  logic signed [EXP_W+1:0] exp_ab    [NLANES];
  logic signed [EXP_W+1:0] s1_exp_ab [NLANES];
  logic [3:0] lane_flags [NLANES];
  logic [3:0] beat_flags;

  // in_ready stays low through reset and rises one cycle after it lifts
  assign s2_adv   = ~out_valid | out_ready;
  assign s1_adv   = ~s1_valid | s2_adv;
  assign in_ready = alive & s1_adv;
  assign accept   = in_valid & in_ready;

  for (genvar i = 0; i < NLANES; i++) begin : g_lane
    spec_lane_resolve #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_lane (
      .a          (in_a[i*W +: W]),
      .b          (in_b[i*W +: W]),
      .c          (in_c[i*W +: W]),
      .cls_a      (cls_a[i]),
      .cls_b      (cls_b[i]),
      .cls_c      (cls_c[i]),
      .exp_ab     (exp_ab[i]),
      .sign_ab    (sign_ab[i]),
      .s1_a       (s1_a[i*W +: W]),
      .s1_b       (s1_b[i*W +: W]),
      .s1_c       (s1_c[i*W +: W]),
      .s1_cls_a   (s1_cls_a[i]),
      .s1_cls_b   (s1_cls_b[i]),
      .s1_cls_c   (s1_cls_c[i]),
      .s1_exp_ab  (s1_exp_ab[i]),
      .s1_sign_ab (s1_sign_ab[i]),
      .s1_inv     (s1_inv[i]),
      .s1_nj      (s1_nj),
      .spec       (lane_spec[i]),
      .res        (lane_res[i*W +: W]),
      .flags      (lane_flags[i])
    );
  end

  always_comb begin
    beat_flags = '0;
    for (int i = 0; i < NLANES; i++) beat_flags = beat_flags | lane_flags[i];
  end

  always_ff @(posedge clk) begin
    alive <= ~rst;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= accept;
      if (accept) begin
        s1_tag     <= in_tag;
        s1_nj      <= nj_mode;
        s1_inv     <= in_inv_mask;
        s1_a       <= in_a;
        s1_b       <= in_b;
        s1_c       <= in_c;
        s1_sign_ab <= sign_ab;
        for (int i = 0; i < NLANES; i++) begin
          s1_cls_a[i]  <= cls_a[i];
          s1_cls_b[i]  <= cls_b[i];
          s1_cls_c[i]  <= cls_c[i];
          s1_exp_ab[i] <= exp_ab[i];
        end
      end
    end
  end

  // Output stage doubles as S2; it only loads when downstream can take a beat
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid     <= 1'b0;
      out_spec_mask <= '0;
      out_res       <= '0;
      out_tag       <= '0;
      out_flags     <= '0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_spec_mask <= lane_spec;
        out_res       <= lane_res;
        out_tag       <= s1_tag;
        out_flags     <= beat_flags;
      end
    end
  end

`ifdef SPEC_STICKY_FLAGS_EN
  // A flag delivered in the same cycle as a clear survives the clear
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_flags <= '0;
    end else begin
      sticky_flags <= (flags_clr ? 4'b0000 : sticky_flags) |
                      ((out_valid & out_ready) ? out_flags : 4'b0000);
    end
  end
`endif

endmodule

// File: tb/tb_spec_handler_pipe.sv
// Scoreboard bench for spec_handler_pipe: directed special cases, then random
// beats with random downstream stalls and a mid-stream reset.
module tb_spec_handler_pipe;

  localparam int NL = 4;
  localparam int W  = 32;
  localparam int TW = 4;

  typedef struct packed {
    logic [NL-1:0]   mask;
    logic [NL*W-1:0] res;
    logic [TW-1:0]   tag;
    logic [3:0]      flags;
  } exp_t;

  logic clk = 1'b0;
  logic rst, nj_mode, in_valid, in_ready, out_valid, out_ready;
  logic [NL-1:0]   in_inv_mask, out_spec_mask;
  logic [NL*W-1:0] in_a, in_b, in_c, out_res;
  logic [TW-1:0]   in_tag, out_tag, tag_ctr;
  logic [3:0]      out_flags;
  logic            stall_en = 1'b0;
  logic [3:0]      sticky_model = 4'b0000;
`ifdef SPEC_STICKY_FLAGS_EN
  logic            flags_clr = 1'b0;
  logic [3:0]      sticky_flags;
`endif

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  spec_handler_pipe #(.NLANES(NL), .EXP_W(8), .MAN_W(23), .TAG_W(TW)) dut (
    .clk           (clk),
    .rst           (rst),
    .nj_mode       (nj_mode),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_inv_mask   (in_inv_mask),
    .in_a          (in_a),
    .in_b          (in_b),
    .in_c          (in_c),
    .in_tag        (in_tag),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_spec_mask (out_spec_mask),
    .out_res       (out_res),
    .out_tag       (out_tag),
`ifdef SPEC_STICKY_FLAGS_EN
    .flags_clr     (flags_clr),
    .sticky_flags  (sticky_flags),
`endif
    .out_flags     (out_flags)
  );

  // Reference model for one fp32 lane, working on field values as integers
  function automatic logic [36:0] model_lane(input logic [31:0] a, input logic [31:0] b,
                                             input logic [31:0] c, input logic inv, input logic nj);
    bit nan_a, nan_b, nan_c, inf_a, inf_b, inf_c, zero_a, zero_b, fin_a, fin_b;
    bit sab;
    int e;
    nan_a  = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    nan_b  = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    nan_c  = (c[30:23] == 8'hFF) && (c[22:0] != 0);
    inf_a  = (a[30:0] == 31'h7F800000);
    inf_b  = (b[30:0] == 31'h7F800000);
    inf_c  = (c[30:0] == 31'h7F800000);
    zero_a = (a[30:0] == 0);
    zero_b = (b[30:0] == 0);
    fin_a  = !zero_a && (a[30:23] != 8'hFF);
    fin_b  = !zero_b && (b[30:23] != 8'hFF);
    sab    = a[31] ^ b[31];
    e      = int'(a[30:23]) + int'(b[30:23]) - 254;
    if (nan_a)      return {1'b1, 4'b1000, a | 32'h0040_0000};
    if (nan_b)      return {1'b1, 4'b1000, b | 32'h0040_0000};
    if (nan_c)      return {1'b1, 4'b1000, c | 32'h0040_0000};
    if ((inf_a && zero_b) || (zero_a && inf_b) || (inv && inf_c && (inf_a || inf_b) && (sab != c[31])))
      return {1'b1, 4'b0100, 32'h7FC0_0000};
    if (fin_a && fin_b && e > 127)         return {1'b1, 4'b0010, sab, 31'h7F800000};
    if (fin_a && fin_b && e < -126 && nj)  return {1'b1, 4'b0001, c};
    if (zero_a || zero_b)                  return {1'b1, 4'b0000, inv ? c : {sab, 31'h0}};
    if (inf_a || inf_b)                    return {1'b1, 4'b0000, (!inf_c || !inv) ? {sab, 31'h7F800000} : c};
    if (inf_c)                             return {1'b1, 4'b0000, c};
    return 37'h0;
  endfunction

  function automatic exp_t model_beat(input logic [NL*W-1:0] a, input logic [NL*W-1:0] b,
                                      input logic [NL*W-1:0] c, input logic [NL-1:0] inv,
                                      input logic nj, input logic [TW-1:0] tag);
    exp_t e;
    logic [36:0] r;
    e = '0;
    e.tag = tag;
    for (int i = 0; i < NL; i++) begin
      r = model_lane(a[i*W +: W], b[i*W +: W], c[i*W +: W], inv[i], nj);
      e.mask[i]      = r[36];
      e.flags        = e.flags | r[35:32];
      e.res[i*W +: W] = r[31:0];
    end
    return e;
  endfunction

  function automatic logic [31:0] rand_op();
    logic s;
    s = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 11))
      0:       return {s, 31'h0};
      1:       return {s, 8'hFF, 23'h0};
      2:       return {s, 8'hFF, 23'($urandom_range(1, 23'h7FFFFF))};
      3, 4:    return {s, 8'($urandom_range(200, 254)), 23'($urandom)};
      5, 6:    return {s, 8'($urandom_range(1, 60)), 23'($urandom)};
      7:       return {s, 8'h00, 23'($urandom_range(1, 23'h7FFFFF))};
      default: return {s, 8'($urandom_range(1, 254)), 23'($urandom)};
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Called just after a rising edge; returns just after the edge that took the beat
  task automatic applyStimulus(input logic [NL*W-1:0] a, input logic [NL*W-1:0] b,
                               input logic [NL*W-1:0] c, input logic [NL-1:0] inv, input logic nj);
    int n;
    in_a = a; in_b = b; in_c = c; in_inv_mask = inv; nj_mode = nj;
    in_tag = tag_ctr; in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) checkOutput("accept_timeout", 256'(in_ready), 256'd1);
    else sb.push_back(model_beat(a, b, c, inv, nj, tag_ctr));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    tag_ctr  = tag_ctr + 1'b1;
  endtask

  task automatic randomBeat();
    logic [NL*W-1:0] a, b, c;
    for (int i = 0; i < NL; i++) begin
      a[i*W +: W] = rand_op();
      b[i*W +: W] = rand_op();
      c[i*W +: W] = rand_op();
    end
    applyStimulus(a, b, c, 4'($urandom), 1'($urandom));
  endtask

  task automatic midReset();
    in_valid = 1'b0;
    rst = 1'b1;
    sb.delete();
    sticky_model = 4'b0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("midrst_out_valid", 256'(out_valid), 256'd0);
    checkOutput("midrst_in_ready", 256'(in_ready), 256'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Downstream back-pressure, changed only just after rising edges
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  // Monitor: compares the head of the scoreboard whenever a beat is presented
  logic [255:0] prev_out;
  logic         prev_stall = 1'b0;
  logic [255:0] cur_out;
  always @(negedge clk) begin
    cur_out = 256'({out_valid, out_spec_mask, out_res, out_tag, out_flags});
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) checkOutput("hold_while_stalled", cur_out, prev_out);
      if (out_valid) begin
        if (sb.size() == 0) begin
          checkOutput("spurious_out_valid", 256'(out_valid), 256'd0);
        end else begin
          checkOutput("tag", 256'(out_tag), 256'(sb[0].tag));
          checkOutput("spec_mask", 256'(out_spec_mask), 256'(sb[0].mask));
          checkOutput("res", 256'(out_res), 256'(sb[0].res));
          checkOutput("flags", 256'(out_flags), 256'(sb[0].flags));
          if (out_ready) begin
            sticky_model = sticky_model | sb[0].flags;
            void'(sb.pop_front());
          end
        end
      end
      prev_out   = cur_out;
      prev_stall = out_valid & ~out_ready;
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    rst = 1'b1; in_valid = 1'b1; nj_mode = 1'b0; in_inv_mask = '1; tag_ctr = '0; in_tag = '0;
    in_a = {4{32'h7F800000}}; in_b = '0; in_c = {4{32'h3F800000}};
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_out_valid", 256'(out_valid), 256'd0);
    checkOutput("rst_in_ready", 256'(in_ready), 256'd0);
    checkOutput("rst_spec_mask", 256'(out_spec_mask), 256'd0);
    checkOutput("rst_res", 256'(out_res), 256'd0);
    checkOutput("rst_tag", 256'(out_tag), 256'd0);
    checkOutput("rst_flags", 256'(out_flags), 256'd0);
    @(posedge clk);
    #1;
    rst = 1'b0; in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("in_ready_after_rst", 256'(in_ready), 256'd1);
    @(posedge clk);
    #1;

    // inf*0 / overflow / signalling NaN / ordinary lane, then a latency check
    applyStimulus({32'h3F800000, 32'hFF800001, 32'h7F000000, 32'h7F800000},
                  {32'h3F800000, 32'h3F800000, 32'h7F000000, 32'h00000000},
                  {32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000}, 4'b0000, 1'b0);
    @(negedge clk);
    checkOutput("latency_cycle1_valid", 256'(out_valid), 256'd0);
    @(negedge clk);
    checkOutput("latency_cycle2_valid", 256'(out_valid), 256'd1);
    @(posedge clk);
    #1;

    // Underflow with and without nj_mode, then invalid and same-sign inf addend
    applyStimulus({32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h00800000},
                  {32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h00800000},
                  {32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h40000000}, 4'b0001, 1'b1);
    applyStimulus({32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h00800000},
                  {32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h00800000},
                  {32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h40000000}, 4'b0001, 1'b0);
    applyStimulus({32'h3F800000, 32'h3F800000, 32'h7F800000, 32'h7F800000},
                  {32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000},
                  {32'h3F800000, 32'h3F800000, 32'h7F800000, 32'hFF800000}, 4'b0011, 1'b0);

    stall_en = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (i == 150) midReset();
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      randomBeat();
    end
    stall_en = 1'b0;

    n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    checkOutput("drain_all_beats", 256'(sb.size()), 256'd0);
    repeat (3) @(posedge clk);
`ifdef SPEC_STICKY_FLAGS_EN
    @(negedge clk);
    checkOutput("sticky_flags", 256'(sticky_flags), 256'(sticky_model));
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
